// File: rtl/instr_mem_seq.sv
// instr_mem_seq: writable instruction store with a built-in fetch sequencer.
// A host loads frames through the write port while the sequencer is idle or done.
// After start, frames are streamed from address 0 up to the sampled last address
// over a valid/ready interface, one frame every two cycles (synchronous read bubble).
// Frame layout, MSB->LSB: {a_in[DATA_W], b_in[DATA_W], c_in, op_code[OP_W]}.
// Optional feature macro: INSTR_MEM_SEQ_LOOP_EN (wrap to address 0 after the last frame
// instead of stopping in DONE).
module instr_mem_seq #(
  parameter int DATA_W = 4,
  parameter int OP_W   = 4,
  parameter int ADDR_W = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [2*DATA_W+OP_W:0]   wr_data,
  input  logic [ADDR_W-1:0]        last_addr,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [2*DATA_W+OP_W:0]   frame,
  output logic [ADDR_W-1:0]        pc,
  output logic                     busy,
  output logic                     done
);

  localparam int FRAME_W = 2*DATA_W + 1 + OP_W;
  localparam int DEPTH   = 2**ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [FRAME_W-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   last_q, last_d;
  logic [FRAME_W-1:0]  frame_q;
  logic                load_frame;
  logic                wr_ok;

  // Host writes are only accepted while the sequencer is not reading the array,
  // so a write can never collide with an in-flight fetch.
  assign wr_ok = wr_en & ((state_q == IDLE) | (state_q == DONE));

  // Storage array; intentionally not reset so a loaded program survives rst_n.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Sequencer state, program counter, sampled last address and the frame register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      last_q  <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      last_q  <= last_d;
      if (load_frame) begin
        frame_q <= mem[pc_q];
      end
    end
  end

  // Next-state logic: stop beats start, start beats the handshake, then normal sequencing.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    last_d     = last_q;
    load_frame = 1'b0;
    if (stop) begin
      state_d = IDLE;
      pc_d    = '0;
    end else if (start) begin
      state_d = FETCH;
      pc_d    = '0;
      last_d  = last_addr;
    end else begin
      case (state_q)
        FETCH: begin
          state_d    = VALID;
          load_frame = 1'b1;
        end
        VALID: begin
          if (out_ready) begin
            if (pc_q != last_q) begin
              pc_d    = pc_q + ADDR_W'(1);
              state_d = FETCH;
            end else begin
`ifdef INSTR_MEM_SEQ_LOOP_EN
              pc_d    = '0;
              state_d = FETCH;
`else
              state_d = DONE;
`endif
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = (state_q == VALID);
  assign frame     = frame_q;
  assign pc        = pc_q;
  assign busy      = (state_q == FETCH) | (state_q == VALID);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_instr_mem_seq.sv
// tb_instr_mem_seq: self-checking bench for instr_mem_seq.
// Keeps a plain array copy of the program and predicts the streamed frames from it.
module tb_instr_mem_seq;

  localparam int DW    = 4;
  localparam int OW    = 4;
  localparam int AW    = 3;
  localparam int FW    = 2*DW + 1 + OW;
  localparam int DEPTH = 2**AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [FW-1:0] wr_data = '0;
  logic [AW-1:0] last_addr = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [FW-1:0] frame;
  logic [AW-1:0] pc;
  logic          busy;
  logic          done;

  int total = 0;
  int bad   = 0;

  logic [FW-1:0] model_mem [DEPTH];
  logic [FW-1:0] cap_frame [$];
  logic [AW-1:0] cap_pc [$];
  int            cap_cycle [$];
  int            stable_viol;

  instr_mem_seq #(.DATA_W(DW), .OP_W(OW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .last_addr(last_addr), .start(start), .stop(stop), .out_ready(out_ready),
    .out_valid(out_valid), .frame(frame), .pc(pc), .busy(busy), .done(done)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int addr, input logic [FW-1:0] data);
    wr_en = 1'b1; wr_addr = AW'(addr); wr_data = data;
    step();
    wr_en = 1'b0;
    model_mem[addr] = data;
  endtask

  task automatic do_start(input int last);
    last_addr = AW'(last); start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  // Runs the consumer side and records every accepted frame; does no checking itself.
  task automatic collect(input int max_frames, input int budget, input bit rand_ready);
    logic pv, pr;
    logic [FW-1:0] pf;
    logic [AW-1:0] pp;
    cap_frame.delete(); cap_pc.delete(); cap_cycle.delete();
    stable_viol = 0;
    pv = 1'b0; pr = 1'b1; pf = '0; pp = '0;
    for (int cyc = 0; cyc < budget && cap_frame.size() < max_frames; cyc++) begin
      if (pv && !pr && (out_valid !== 1'b1 || frame !== pf || pc !== pp)) stable_viol++;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid === 1'b1 && out_ready) begin
        cap_frame.push_back(frame);
        cap_pc.push_back(pc);
        cap_cycle.push_back(cyc);
      end
      pv = out_valid; pr = out_ready; pf = frame; pp = pc;
      step();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", out_valid); end
    total++; if (frame !== '0) begin bad++; $display("[TB] FAIL reset_frame got=%h want=0", frame); end
    total++; if (pc !== '0) begin bad++; $display("[TB] FAIL reset_pc got=%0d want=0", pc); end
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("[TB] FAIL reset_flags got busy=%b done=%b want 0/0", busy, done); end
    step(); step();
    rst_n = 1'b1;
    step();
    total++; if (busy !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_idle got busy=%b valid=%b want 0/0", busy, out_valid); end
  endtask

  task automatic load_program();
    load(0, 13'b0010_1000_1_0000);
    for (int a = 1; a < DEPTH; a++) load(a, FW'($urandom));
  endtask

  task automatic test_stream_basic();
    do_start(5);
    collect(6, 40, 1'b0);
    total++; if (cap_frame.size() != 6) begin bad++; $display("[TB] FAIL basic_count got=%0d want=6", cap_frame.size()); end
    for (int i = 0; i < cap_frame.size(); i++) begin
      total++; if (cap_frame[i] !== model_mem[i] || cap_pc[i] !== AW'(i)) begin bad++; $display("[TB] FAIL basic_frame%0d got=%h pc=%0d want=%h pc=%0d", i, cap_frame[i], cap_pc[i], model_mem[i], i); end
      total++; if (cap_cycle[i] != 1 + 2*i) begin bad++; $display("[TB] FAIL basic_timing%0d got=%0d want=%0d", i, cap_cycle[i], 1 + 2*i); end
    end
    total++; if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || pc !== AW'(5)) begin bad++; $display("[TB] FAIL basic_done got done=%b busy=%b valid=%b pc=%0d want 1/0/0/5", done, busy, out_valid, pc); end
  endtask

  task automatic test_backpressure();
    int guard;
    do_start(5);
    out_ready = 1'b1;
    guard = 0;
    while (!(out_valid === 1'b1 && pc === AW'(2)) && guard < 20) begin step(); guard++; end
    out_ready = 1'b0;
    total++; if (guard >= 20) begin bad++; $display("[TB] FAIL bp_reach got=timeout want=frame2"); end
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (out_valid !== 1'b1 || frame !== model_mem[2] || pc !== AW'(2)) begin bad++; $display("[TB] FAIL bp_hold%0d got valid=%b frame=%h pc=%0d want 1/%h/2", i, out_valid, frame, pc, model_mem[2]); end
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_bubble got=%b want=0", out_valid); end
    step();
    total++; if (out_valid !== 1'b1 || frame !== model_mem[3] || pc !== AW'(3)) begin bad++; $display("[TB] FAIL bp_next got valid=%b frame=%h pc=%0d want 1/%h/3", out_valid, frame, pc, model_mem[3]); end
    do_stop();
  endtask

  task automatic test_reset_midstream();
    do_start(5);
    step();
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || frame !== '0 || pc !== '0 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("[TB] FAIL async_reset got valid=%b frame=%h pc=%0d busy=%b done=%b want all 0", out_valid, frame, pc, busy, done); end
    #2 rst_n = 1'b1;
    step();
    do_start(5);
    collect(6, 200, 1'b1);
    total++; if (cap_frame.size() != 6) begin bad++; $display("[TB] FAIL rerun_count got=%0d want=6", cap_frame.size()); end
    for (int i = 0; i < cap_frame.size(); i++) begin
      total++; if (cap_frame[i] !== model_mem[i]) begin bad++; $display("[TB] FAIL rerun_frame%0d got=%h want=%h", i, cap_frame[i], model_mem[i]); end
    end
    total++; if (stable_viol != 0) begin bad++; $display("[TB] FAIL rerun_stable got=%0d want=0", stable_viol); end
  endtask

  task automatic test_write_busy();
    do_start(3);
    step();
    wr_en = 1'b1; wr_addr = AW'(1); wr_data = 13'h1FFF;
    step(); step();
    wr_en = 1'b0;
    do_stop();
    do_start(3);
    collect(4, 40, 1'b0);
    total++; if (cap_frame.size() != 4) begin bad++; $display("[TB] FAIL wbusy_count got=%0d want=4", cap_frame.size()); end
    total++; if (cap_frame.size() > 1 && cap_frame[1] !== model_mem[1]) begin bad++; $display("[TB] FAIL wbusy_addr1 got=%h want=%h", cap_frame[1], model_mem[1]); end
  endtask

  task automatic test_restart_busy();
    do_start(5);
    collect(2, 20, 1'b0);
    step();
    do_start(2);
    total++; if (out_valid !== 1'b0 || pc !== '0 || busy !== 1'b1) begin bad++; $display("[TB] FAIL restart got valid=%b pc=%0d busy=%b want 0/0/1", out_valid, pc, busy); end
    collect(3, 30, 1'b0);
    total++; if (cap_frame.size() != 3) begin bad++; $display("[TB] FAIL restart_count got=%0d want=3", cap_frame.size()); end
    for (int i = 0; i < cap_frame.size(); i++) begin
      total++; if (cap_frame[i] !== model_mem[i]) begin bad++; $display("[TB] FAIL restart_frame%0d got=%h want=%h", i, cap_frame[i], model_mem[i]); end
    end
  endtask

  task automatic test_stop_start();
    do_start(5);
    step();
    stop = 1'b1; start = 1'b1;
    step();
    stop = 1'b0; start = 1'b0;
    total++; if (out_valid !== 1'b0 || pc !== '0 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("[TB] FAIL stopstart got valid=%b pc=%0d busy=%b done=%b want 0/0/0/0", out_valid, pc, busy, done); end
    total++; if (frame !== model_mem[0]) begin bad++; $display("[TB] FAIL stop_frame_kept got=%h want=%h", frame, model_mem[0]); end
    do_start(0);
    collect(1, 20, 1'b0);
    for (int i = 0; i < 3; i++) step();
    total++; if (cap_frame.size() != 1 || cap_frame[0] !== model_mem[0]) begin bad++; $display("[TB] FAIL single_frame got n=%0d want n=1 frame=%h", cap_frame.size(), model_mem[0]); end
    total++; if (done !== 1'b1 || out_valid !== 1'b0 || pc !== '0) begin bad++; $display("[TB] FAIL single_done got done=%b valid=%b pc=%0d want 1/0/0", done, out_valid, pc); end
  endtask

  task automatic test_random();
    int last;
    for (int it = 0; it < 6; it++) begin
      load($urandom_range(0, DEPTH-1), FW'($urandom));
      load($urandom_range(0, DEPTH-1), FW'($urandom));
      last = (it == 0) ? DEPTH-1 : $urandom_range(0, DEPTH-1);
      do_start(last);
      collect(last + 1, 300, 1'b1);
      total++; if (cap_frame.size() != last + 1) begin bad++; $display("[TB] FAIL rand%0d_count got=%0d want=%0d", it, cap_frame.size(), last + 1); end
      for (int i = 0; i < cap_frame.size(); i++) begin
        total++; if (cap_frame[i] !== model_mem[i] || cap_pc[i] !== AW'(i)) begin bad++; $display("[TB] FAIL rand%0d_frame%0d got=%h pc=%0d want=%h pc=%0d", it, i, cap_frame[i], cap_pc[i], model_mem[i], i); end
      end
      total++; if (stable_viol != 0) begin bad++; $display("[TB] FAIL rand%0d_stable got=%0d want=0", it, stable_viol); end
      total++; if (done !== 1'b1 || pc !== AW'(last)) begin bad++; $display("[TB] FAIL rand%0d_done got done=%b pc=%0d want 1/%0d", it, done, pc, last); end
    end
  endtask

  task automatic test_loop();
    do_start(2);
    collect(8, 60, 1'b0);
    total++; if (cap_frame.size() != 8) begin bad++; $display("[TB] FAIL loop_count got=%0d want=8", cap_frame.size()); end
    for (int i = 0; i < cap_frame.size(); i++) begin
      total++; if (cap_frame[i] !== model_mem[i % 3]) begin bad++; $display("[TB] FAIL loop_frame%0d got=%h want=%h", i, cap_frame[i], model_mem[i % 3]); end
    end
    total++; if (done !== 1'b0 || busy !== 1'b1) begin bad++; $display("[TB] FAIL loop_flags got done=%b busy=%b want 0/1", done, busy); end
    do_stop();
  endtask

  // Scenario sequence; everything is bounded so the run always reaches the summary.
  initial begin
    test_reset();
    load_program();
`ifdef INSTR_MEM_SEQ_LOOP_EN
    test_loop();
`else
    test_stream_basic();
    test_backpressure();
    test_reset_midstream();
    test_write_busy();
    test_restart_busy();
    test_stop_start();
    test_random();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
